wb_merge_queue: RTL and testbench

//  Writeback merge stage directly upstream of the 32-entry register file's single write port.

---
 rtl/wb_merge_if.sv | 40 ++++
 rtl/wb_merge_queue.sv | 122 ++++++++++++
 tb/tb_wb_merge_queue.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_merge_if.sv
// Producer, hazard-query and register-file write signals of the writeback merge queue.
// master = producers/decode/regfile side, slave = the merge queue itself.
interface wb_merge_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             mem_valid;
    logic [4:0]       mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic             alu_valid;
    logic [4:0]       alu_wa;
    logic [WIDTH-1:0] alu_wd;
    logic             in_ready;
    logic [4:0]       ra0;
    logic [4:0]       ra1;
    logic             hit0;
    logic             hit1;
    logic             wb_we;
    logic [4:0]       wb_wa;
    logic [WIDTH-1:0] wb_wd;
    logic [CW-1:0]    count;

    modport master (
        output mem_valid, mem_wa, mem_wd,
        output alu_valid, alu_wa, alu_wd,
        output ra0, ra1,
        input  in_ready, hit0, hit1,
        input  wb_we, wb_wa, wb_wd, count
    );

    modport slave (
        input  mem_valid, mem_wa, mem_wd,
        input  alu_valid, alu_wa, alu_wd,
        input  ra0, ra1,
        output in_ready, hit0, hit1,
        output wb_we, wb_wa, wb_wd, count
    );
endinterface

// File: rtl/wb_merge_queue.sv
// Merges load-return and ALU results into one in-order register-file write stream.
// Latency: push at edge N, popped at edge N+1, wb_we high the cycle after N+1.
// Backpressure: in_ready drops unless two free slots remain; producers hold data while low.
module wb_merge_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input logic      clk,
    input logic      rst,
    wb_merge_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    typedef struct packed {
        logic [4:0]       wa;
        logic [WIDTH-1:0] wd;
    } entry_t;

    entry_t           q_ent [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;

    logic             we_q;
    logic [4:0]       wa_q;
    logic [WIDTH-1:0] wd_q;

    logic             in_ready_c;
    logic             push_mem;
    logic             push_alu;
    logic             pop;
    logic [PW-1:0]    alu_slot;
    logic [PW-1:0]    tail_nxt;
    logic [CW-1:0]    count_nxt;
    logic             hit0_c;
    logic             hit1_c;

    // Two free slots are required so a dual push never depends on a same-cycle pop.
    assign in_ready_c = (count_q <= READY_MAX);
    assign push_mem   = bus.mem_valid && in_ready_c;
    assign push_alu   = bus.alu_valid && in_ready_c;
    assign pop        = (count_q != '0);

    // mem is the older producer, so it claims the tail slot first.
    assign alu_slot  = tail + PW'(push_mem);
    assign tail_nxt  = tail + PW'(push_mem) + PW'(push_alu);
    assign count_nxt = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            q_vld   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            if (pop) begin
                wa_q        <= q_ent[head].wa;
                wd_q        <= q_ent[head].wd;
                we_q        <= (q_ent[head].wa != 5'd0);
                q_vld[head] <= 1'b0;
                head        <= head + PW'(1);
            end else begin
                we_q <= 1'b0;
            end
            if (push_mem) begin
                q_vld[tail] <= 1'b1;
            end
            if (push_alu) begin
                q_vld[alu_slot] <= 1'b1;
            end
            tail    <= tail_nxt;
            count_q <= count_nxt;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by q_vld and count_q.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push_mem) begin
                q_ent[tail] <= '{wa: bus.mem_wa, wd: bus.mem_wd};
            end
            if (push_alu) begin
                q_ent[alu_slot] <= '{wa: bus.alu_wa, wd: bus.alu_wd};
            end
        end
    end

    // The output register is deliberately excluded: the regfile bypass covers that cycle.
    always_comb begin
        hit0_c = 1'b0;
        hit1_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_ent[i].wa == bus.ra0)) begin
                hit0_c = 1'b1;
            end
            if (q_vld[i] && (q_ent[i].wa == bus.ra1)) begin
                hit1_c = 1'b1;
            end
        end
        if (bus.ra0 == 5'd0) begin
            hit0_c = 1'b0;
        end
        if (bus.ra1 == 5'd0) begin
            hit1_c = 1'b0;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.hit0     = hit0_c;
    assign bus.hit1     = hit1_c;
    assign bus.wb_we    = we_q;
    assign bus.wb_wa    = wa_q;
    assign bus.wb_wd    = wd_q;
    assign bus.count    = count_q;

endmodule

// File: tb/tb_wb_merge_queue.sv
// Directed bench for wb_merge_queue: reset, latency, ordering, backpressure, hazards.
module tb_wb_merge_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    wr_t  exp_q[$];

    wb_merge_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    wb_merge_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one cycle and match any register-file write against the expected stream.
    task automatic tick_collect();
        wr_t e;
        tick();
        if (bus.wb_we) begin
            if (exp_q.size() == 0) begin
                chk("extra_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("stream_wa", 32'(bus.wb_wa), 32'(e.wa));
                chk("stream_wd", bus.wb_wd, e.wd);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
    endtask

    initial begin
        bit exp_rdy [6];
        int exp_cnt [6];
        int p;

        vectors     = 0;
        miscompares = 0;
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_cnt = '{2, 3, 2, 3, 2, 3};

        rst        = 1'b1;
        bus.mem_wa = '0;
        bus.mem_wd = '0;
        bus.alu_wa = '0;
        bus.alu_wd = '0;
        bus.ra0    = '0;
        bus.ra1    = '0;
        idle_inputs();

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_we", 32'(bus.wb_we), 32'd0);
        chk("rst_wa", 32'(bus.wb_wa), 32'd0);
        chk("rst_wd", bus.wb_wd, 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        // Single ALU push: write appears in the cycle after the pop edge only
        bus.alu_valid = 1'b1;
        bus.alu_wa    = 5'd5;
        bus.alu_wd    = 32'h0000_1234;
        tick();
        idle_inputs();
        chk("single_count", 32'(bus.count), 32'd1);
        chk("single_we_early", 32'(bus.wb_we), 32'd0);
        tick();
        chk("single_we", 32'(bus.wb_we), 32'd1);
        chk("single_wa", 32'(bus.wb_wa), 32'd5);
        chk("single_wd", bus.wb_wd, 32'h0000_1234);
        chk("single_count_pop", 32'(bus.count), 32'd0);
        tick();
        chk("single_we_after", 32'(bus.wb_we), 32'd0);
        chk("single_wa_hold", 32'(bus.wb_wa), 32'd5);
        chk("single_wd_hold", bus.wb_wd, 32'h0000_1234);

        // Hazard tracking for a queued write to r7
        bus.ra0       = 5'd7;
        bus.ra1       = 5'd8;
        bus.alu_valid = 1'b1;
        bus.alu_wa    = 5'd7;
        bus.alu_wd    = 32'h0000_0077;
        #1;
        chk("hz_hit0_same_cycle", 32'(bus.hit0), 32'd0);
        chk("hz_hit1_same_cycle", 32'(bus.hit1), 32'd0);
        tick();
        idle_inputs();
        chk("hz_hit0_queued", 32'(bus.hit0), 32'd1);
        chk("hz_hit1_queued", 32'(bus.hit1), 32'd0);
        tick();
        chk("hz_hit0_popped", 32'(bus.hit0), 32'd0);
        chk("hz_hit1_popped", 32'(bus.hit1), 32'd0);
        chk("hz_we", 32'(bus.wb_we), 32'd1);
        chk("hz_wa", 32'(bus.wb_wa), 32'd7);
        tick();

        // Simultaneous pushes to r3: mem is older, so alu's value lands last
        bus.mem_valid = 1'b1;
        bus.mem_wa    = 5'd3;
        bus.mem_wd    = 32'h0000_AAAA;
        bus.alu_valid = 1'b1;
        bus.alu_wa    = 5'd3;
        bus.alu_wd    = 32'h0000_BBBB;
        tick();
        idle_inputs();
        chk("dual_count", 32'(bus.count), 32'd2);
        tick();
        chk("dual_we0", 32'(bus.wb_we), 32'd1);
        chk("dual_wa0", 32'(bus.wb_wa), 32'd3);
        chk("dual_wd0", bus.wb_wd, 32'h0000_AAAA);
        tick();
        chk("dual_we1", 32'(bus.wb_we), 32'd1);
        chk("dual_wa1", 32'(bus.wb_wa), 32'd3);
        chk("dual_wd1", bus.wb_wd, 32'h0000_BBBB);
        tick();
        chk("dual_we_after", 32'(bus.wb_we), 32'd0);

        // Writes to r0 are consumed silently and never flag a hazard
        bus.ra0       = 5'd0;
        bus.alu_valid = 1'b1;
        bus.alu_wa    = 5'd0;
        bus.alu_wd    = 32'h0000_FFFF;
        tick();
        idle_inputs();
        chk("r0_count", 32'(bus.count), 32'd1);
        chk("r0_hit0_queued", 32'(bus.hit0), 32'd0);
        tick();
        chk("r0_we", 32'(bus.wb_we), 32'd0);
        chk("r0_wd", bus.wb_wd, 32'h0000_FFFF);
        chk("r0_hit0_after", 32'(bus.hit0), 32'd0);
        chk("r0_count_pop", 32'(bus.count), 32'd0);

        // Saturating dual input: producers hold data while in_ready is low
        p = 0;
        for (int k = 0; k < 6; k++) begin
            bus.mem_valid = 1'b1;
            bus.mem_wa    = 5'(8 + 2 * p);
            bus.mem_wd    = 32'h100 + 32'(p);
            bus.alu_valid = 1'b1;
            bus.alu_wa    = 5'(9 + 2 * p);
            bus.alu_wd    = 32'h200 + 32'(p);
            chk($sformatf("sat_ready_%0d", k), 32'(bus.in_ready), 32'(exp_rdy[k]));
            if (exp_rdy[k]) begin
                exp_q.push_back('{wa: 5'(8 + 2 * p), wd: 32'h100 + 32'(p)});
                exp_q.push_back('{wa: 5'(9 + 2 * p), wd: 32'h200 + 32'(p)});
                p++;
            end
            tick_collect();
            chk($sformatf("sat_count_%0d", k), 32'(bus.count), 32'(exp_cnt[k]));
        end
        idle_inputs();
        repeat (12) tick_collect();
        chk("sat_all_drained", 32'(exp_q.size()), 32'd0);
        chk("sat_count_end", 32'(bus.count), 32'd0);

        // Mid-run reset with three entries queued and producers still pushing
        bus.mem_valid = 1'b1;
        bus.mem_wa    = 5'd20;
        bus.mem_wd    = 32'h0000_0020;
        bus.alu_valid = 1'b1;
        bus.alu_wa    = 5'd21;
        bus.alu_wd    = 32'h0000_0021;
        tick();
        bus.mem_wa = 5'd22;
        bus.mem_wd = 32'h0000_0022;
        bus.alu_wa = 5'd23;
        bus.alu_wd = 32'h0000_0023;
        tick();
        chk("mr_count_pre", 32'(bus.count), 32'd3);
        chk("mr_wa_pre", 32'(bus.wb_wa), 32'd20);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        idle_inputs();
        chk("mr_count", 32'(bus.count), 32'd0);
        chk("mr_we", 32'(bus.wb_we), 32'd0);
        chk("mr_ready", 32'(bus.in_ready), 32'd1);
        chk("mr_wa", 32'(bus.wb_wa), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("mr_no_write_%0d", k), 32'(bus.wb_we), 32'd0);
            chk($sformatf("mr_count_hold_%0d", k), 32'(bus.count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule
